// File: rtl/median_frame_ctrl.sv
// Frame sequencer for the 7x7 median path: paces upstream pixels into the filter,
// injects flush pixels to drain the window, and tags kept results with (row, col).
module median_frame_ctrl #(
    parameter int         IMAGE_WIDTH   = 320,
    parameter int         MAX_HEIGHT    = 1024,
    parameter int         RADIUS        = 3,
    parameter int         GAP_CYCLES    = 6,
    parameter logic [7:0] FLUSH_VALUE   = 8'd0,
    parameter int         DRAIN_TIMEOUT = 4096,
    localparam int        LEAD = RADIUS * IMAGE_WIDTH + RADIUS,
    localparam int        CW   = $clog2(IMAGE_WIDTH),
    localparam int        RW   = $clog2(MAX_HEIGHT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [RW-1:0] frame_height,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          f_valid,
    output logic [7:0]    f_data,
    input  logic          f_out_valid,
    input  logic [7:0]    f_out_data,
    output logic          m_valid,
    output logic [7:0]    m_data,
    output logic [RW-1:0] m_row,
    output logic [CW-1:0] m_col,
    output logic          busy,
    output logic          done,
    output logic          timeout_err
);
    // state   | meaning
    // IDLE    | waiting for start with a non-zero height
    // FEED    | forwarding upstream pixels, one per GAP_CYCLES+1 cycles
    // FLUSH   | issuing LEAD flush pixels so the window drains
    // DRAIN   | waiting for the remaining results, bounded by DRAIN_TIMEOUT
    typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_t;

    localparam int KW = $clog2(IMAGE_WIDTH * MAX_HEIGHT + LEAD + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    localparam logic [KW-1:0] LEAD_K   = KW'(LEAD);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
    localparam logic [TW-1:0] TMO_LOAD = TW'(DRAIN_TIMEOUT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);

    state_t        state_q, state_d;
    logic [KW-1:0] total_q, total_d;
    logic [KW-1:0] in_cnt_q, in_cnt_d;
    logic [KW-1:0] res_cnt_q, res_cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          s_ready_q, s_ready_d;
    logic          f_valid_q, f_valid_d;
    logic [7:0]    f_data_q, f_data_d;
    logic          m_valid_q, m_valid_d;
    logic [7:0]    m_data_q, m_data_d;
    logic [RW-1:0] m_row_q, m_row_d;
    logic [CW-1:0] m_col_q, m_col_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tmo_err_q, tmo_err_d;

    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        in_cnt_d  = in_cnt_q;
        res_cnt_d = res_cnt_q;
        gap_d     = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
        tmo_d     = tmo_q;
        row_d     = row_q;
        col_d     = col_q;
        f_valid_d = 1'b0;
        f_data_d  = f_data_q;
        m_valid_d = 1'b0;
        m_data_d  = m_data_q;
        m_row_d   = m_row_q;
        m_col_d   = m_col_q;
        done_d    = 1'b0;
        tmo_err_d = tmo_err_q;

        case (state_q)
            S_IDLE: begin
                if (start && frame_height != '0) begin
                    total_d   = KW'(frame_height) * KW'(IMAGE_WIDTH);
                    in_cnt_d  = '0;
                    res_cnt_d = '0;
                    row_d     = '0;
                    col_d     = '0;
                    gap_d     = '0;
                    tmo_err_d = 1'b0;
                    state_d   = S_FEED;
                end
            end
            S_FEED: begin
                if (s_ready_q && s_valid) begin
                    f_valid_d = 1'b1;
                    f_data_d  = s_data;
                    gap_d     = GAP_LOAD;
                    in_cnt_d  = in_cnt_q + KW'(1);
                    if (in_cnt_q + KW'(1) == total_q) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (gap_q == '0) begin
                    f_valid_d = 1'b1;
                    f_data_d  = FLUSH_VALUE;
                    gap_d     = GAP_LOAD;
                    in_cnt_d  = in_cnt_q + KW'(1);
                    if (in_cnt_q + KW'(1) == total_q + LEAD_K) begin
                        state_d = S_DRAIN;
                        tmo_d   = TMO_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (res_cnt_q == total_q + LEAD_K) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo_q == '0) begin
                    tmo_err_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Result k maps to raster k-LEAD; lead-in and flush results are dropped.
        if (state_q != S_IDLE && f_out_valid) begin
            res_cnt_d = res_cnt_q + KW'(1);
            if (res_cnt_q >= LEAD_K && res_cnt_q < total_q + LEAD_K) begin
                m_valid_d = 1'b1;
                m_data_d  = f_out_data;
                m_row_d   = row_q;
                m_col_d   = col_q;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
        end

        s_ready_d = (state_d == S_FEED) && (gap_d == '0);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            total_q   <= '0;
            in_cnt_q  <= '0;
            res_cnt_q <= '0;
            gap_q     <= '0;
            tmo_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            s_ready_q <= 1'b0;
            f_valid_q <= 1'b0;
            f_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_row_q   <= '0;
            m_col_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            in_cnt_q  <= in_cnt_d;
            res_cnt_q <= res_cnt_d;
            gap_q     <= gap_d;
            tmo_q     <= tmo_d;
            row_q     <= row_d;
            col_q     <= col_d;
            s_ready_q <= s_ready_d;
            f_valid_q <= f_valid_d;
            f_data_q  <= f_data_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_row_q   <= m_row_d;
            m_col_q   <= m_col_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign f_valid     = f_valid_q;
    assign f_data      = f_data_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_row       = m_row_q;
    assign m_col       = m_col_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = tmo_err_q;
endmodule
